// File: rtl/vid_fetch_sched.sv
// Video timing generator with a horizontal-blank scanline prefetch scheduler.
// Pixel counters drive registered sync/blank outputs. During each hblank a run of
// burst reads prefetches the next visible line from the frame buffer. The frame
// buffer base is double-buffered so a new base takes effect at the next frame.
module vid_fetch_sched #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic [1:0]  BURST_CODE = 2'b10,
    parameter int unsigned URGENT_CYC = 32,
    parameter logic [3:0]  MEM_TARGET = 4'h1,
    parameter logic [31:0] FB_BASE    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [2:0]  cmdout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [3:0]  reqtar,
    output logic        hsync,
    output logic        hblank,
    output logic        vsync,
    output logic        vblank,
    output logic        fetch_active,
    output logic        underrun
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned BURSTS  = H_ACTIVE >> BURST_CODE;
    localparam int unsigned BW      = $clog2(BURSTS + 1);

    // Decode thresholds held at 32 bits so counter compares never truncate.
    localparam logic [31:0] H_ACT_C  = 32'(H_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
    localparam logic [31:0] H_TRIG   = 32'(H_ACTIVE - 1);
    localparam logic [31:0] H_URGENT = 32'(H_TOTAL - URGENT_CYC);
    localparam logic [31:0] V_ACT_C  = 32'(V_ACTIVE);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);

    localparam logic [31:0]   LINE_BYTES  = 32'(H_ACTIVE * 4);
    localparam logic [31:0]   BURST_BYTES = 32'(4) << BURST_CODE;
    localparam logic [BW-1:0] BURSTS_C    = BW'(BURSTS);
    localparam logic [BW-1:0] ONE_BURST   = BW'(1);
    localparam logic [2:0]    CMD_READ    = 3'b010;
    localparam logic [2:0]    CMD_WR_BASE = 3'b011;
    localparam logic [2:0]    CMD_CLR_UR  = 3'b100;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e          state_q;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d, next_line;
    logic [31:0]     hcnt_q32, hcnt_d32, vcnt_d32, next_line32;
    logic            h_wrap;
    logic            fetch_line;
    logic            first_line;
    logic            urgent_d;
    logic            cfg_wr_base;
    logic            cfg_clr;
    logic [31:0]     pending_base_q;
    logic [31:0]     line_base_q;
    logic [31:0]     ptr_q;
    logic [31:0]     new_line_addr;
    logic [31:0]     next_ptr;
    logic [BW-1:0]   remaining_q;

    // Counter next-state, fetch trigger and config decode.
    always_comb begin
        hcnt_q32  = 32'(hcnt_q);
        h_wrap    = enable && (hcnt_q32 == H_LAST);
        next_line = (32'(vcnt_q) == V_LAST) ? '0 : vcnt_q + VW'(1);
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        if (enable) begin
            if (h_wrap) begin
                hcnt_d = '0;
                vcnt_d = next_line;
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
        end
        hcnt_d32    = 32'(hcnt_d);
        vcnt_d32    = 32'(vcnt_d);
        next_line32 = 32'(next_line);

        fetch_line  = enable && (hcnt_q32 == H_TRIG) && (next_line32 < V_ACT_C);
        first_line  = (next_line == '0);
        urgent_d    = (hcnt_d32 >= H_URGENT);
        // Line 0 rebases from the pending base; every other line steps one line on.
        new_line_addr = first_line ? pending_base_q : line_base_q + LINE_BYTES;
        next_ptr      = ptr_q + BURST_BYTES;

        cfg_wr_base = selin && (cmdin == CMD_WR_BASE);
        cfg_clr     = selin && (cmdin == CMD_CLR_UR);
    end

    // Pixel counters and registered sync/blank decode of the post-edge count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            hblank <= 1'b0;
            hsync  <= 1'b0;
            vblank <= 1'b0;
            vsync  <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hblank <= (hcnt_d32 >= H_ACT_C);
            hsync  <= (hcnt_d32 >= HS_START) && (hcnt_d32 < HS_END);
            vblank <= (vcnt_d32 >= V_ACT_C);
            vsync  <= (vcnt_d32 >= VS_START) && (vcnt_d32 < VS_END);
        end
    end

    // Fetch FSM with registered bus outputs, base double-buffer and underrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            pending_base_q <= FB_BASE;
            line_base_q    <= FB_BASE;
            ptr_q          <= FB_BASE;
            remaining_q    <= '0;
            underrun       <= 1'b0;
            fetch_active   <= 1'b0;
            reqout         <= 2'b00;
            cmdout         <= 3'b000;
            lenout         <= 2'b00;
            addrdataout    <= 32'h0;
            reqtar         <= 4'h0;
        end else begin
            if (cfg_wr_base) begin
                pending_base_q <= addrdatain;
            end
            // A same-cycle underrun set below overrides this clear.
            if (cfg_clr) begin
                underrun <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (fetch_line) begin
                        state_q      <= StReq;
                        remaining_q  <= BURSTS_C;
                        ptr_q        <= new_line_addr;
                        line_base_q  <= new_line_addr;
                        fetch_active <= 1'b1;
                        reqout       <= {urgent_d, 1'b1};
                        cmdout       <= CMD_READ;
                        lenout       <= BURST_CODE;
                        addrdataout  <= new_line_addr;
                        reqtar       <= MEM_TARGET;
                    end
                end
                StReq: begin
                    if (h_wrap) begin
                        // Line ran out of time: drop the request, keep line_base.
                        state_q      <= StIdle;
                        underrun     <= 1'b1;
                        fetch_active <= 1'b0;
                        reqout       <= 2'b00;
                        cmdout       <= 3'b000;
                        lenout       <= 2'b00;
                        addrdataout  <= 32'h0;
                        reqtar       <= 4'h0;
                    end else if (ackin) begin
                        if (remaining_q == ONE_BURST) begin
                            state_q      <= StIdle;
                            remaining_q  <= '0;
                            fetch_active <= 1'b0;
                            reqout       <= 2'b00;
                            cmdout       <= 3'b000;
                            lenout       <= 2'b00;
                            addrdataout  <= 32'h0;
                            reqtar       <= 4'h0;
                        end else begin
                            ptr_q       <= next_ptr;
                            remaining_q <= remaining_q - ONE_BURST;
                            addrdataout <= next_ptr;
                            reqout      <= {urgent_d, 1'b1};
                        end
                    end else begin
                        reqout[1] <= urgent_d;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
